shk_seq_master: RTL and testbench

SHK_SEQ_MASTER -- requirements
Module: shk_seq_master

---
 rtl/shk_seq_master.sv | 127 ++++++++++++
 tb/tb_shk_seq_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shk_seq_master.sv
// SHK four-phase sequence master: takes one command/data request, drives it to an SHK
// slave, waits for wready (or a timeout), completes the four-phase return and then
// emits a single response strobe.
module shk_seq_master #(
   parameter int unsigned NB_VER      = 0,
   parameter int unsigned WD_SHK_SYNC = 16,
   parameter int unsigned WD_SHK_DLAY = 15,
   parameter int unsigned WD_ERR_INFO = 4,
   parameter int unsigned NB_TIMEOUT  = 1024
) (
   input  logic                   s_sys_a_clock,
   input  logic                   s_sys_a_resetn,
   input  logic                   s_req_valid,
   output logic                   s_req_ready,
   input  logic [WD_SHK_SYNC-1:0] s_req_sync,
   input  logic [WD_SHK_DLAY-1:0] s_req_data,
   output logic                   m_rsp_valid,
   output logic [WD_SHK_SYNC-1:0] m_rsp_sync,
   output logic [WD_SHK_DLAY-1:0] m_rsp_data,
   output logic                   m_rsp_err,
   output logic                   m_shk_wvalid,
   output logic [WD_SHK_SYNC-1:0] m_shk_smosi,
   output logic [WD_SHK_DLAY-1:0] m_shk_dmosi,
   input  logic                   m_shk_wready,
   input  logic [WD_SHK_SYNC-1:0] m_shk_smiso,
   input  logic [WD_SHK_DLAY-1:0] m_shk_dmiso,
   input  logic [WD_ERR_INFO-1:0] s_err_info1,
   output logic [WD_ERR_INFO-1:0] m_err_info1
);

   localparam int unsigned WD_CNT = $clog2(NB_TIMEOUT) + 1;
   localparam logic [WD_CNT-1:0] CNT_LAST = WD_CNT'(NB_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSend, StRelease, StResp} t_state;

   t_state                 r_state;
   t_state                 w_state_nxt;
   logic                   r_alive;
   logic                   r_wvalid;
   logic [WD_SHK_SYNC-1:0] r_smosi;
   logic [WD_SHK_DLAY-1:0] r_dmosi;
   logic [WD_SHK_SYNC-1:0] r_rsp_sync;
   logic [WD_SHK_DLAY-1:0] r_rsp_data;
   logic                   r_rsp_err;
   logic [WD_CNT-1:0]      r_cnt;
   logic                   r_sticky;
   logic                   w_accept;
   logic                   w_done;
   logic                   w_timeout;
   logic [WD_ERR_INFO-1:0] w_err;

   // r_alive keeps ready low while in reset and raises it on the first clock after release
   assign s_req_ready  = (r_state == StIdle) && r_alive;
   assign w_accept     = s_req_ready && s_req_valid;
   assign w_done       = (r_state == StSend) && m_shk_wready;
   // wready in the last allowed cycle wins over the timeout
   assign w_timeout    = (r_state == StSend) && !m_shk_wready && (r_cnt == CNT_LAST);

   assign m_rsp_valid  = (r_state == StResp);
   assign m_rsp_sync   = r_rsp_sync;
   assign m_rsp_data   = r_rsp_data;
   assign m_rsp_err    = r_rsp_err;
   assign m_shk_wvalid = r_wvalid;
   assign m_shk_smosi  = r_smosi;
   assign m_shk_dmosi  = r_dmosi;

   assign w_err        = s_err_info1 | {r_sticky, {(WD_ERR_INFO-1){1'b0}}};
   assign m_err_info1  = (w_err == '0) ? WD_ERR_INFO'(NB_VER) : w_err;

   // State register
   always_ff @(posedge s_sys_a_clock or negedge s_sys_a_resetn) begin
      if (!s_sys_a_resetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:    if (w_accept) w_state_nxt = StSend;
         StSend:    if (w_done || w_timeout) w_state_nxt = StRelease;
         StRelease: if (!m_shk_wready) w_state_nxt = StResp;
         StResp:    w_state_nxt = StIdle;
         default:   w_state_nxt = StIdle;
      endcase
   end

   // Datapath: request capture, SHK valid, response capture, timeout counter, sticky error
   always_ff @(posedge s_sys_a_clock or negedge s_sys_a_resetn) begin
      if (!s_sys_a_resetn) begin
         r_alive    <= 1'b0;
         r_wvalid   <= 1'b0;
         r_smosi    <= '0;
         r_dmosi    <= '0;
         r_rsp_sync <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_cnt      <= '0;
         r_sticky   <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_accept) begin
            r_smosi  <= s_req_sync;
            r_dmosi  <= s_req_data;
            r_wvalid <= 1'b1;
            r_cnt    <= '0;
         end else if (w_done) begin
            r_wvalid   <= 1'b0;
            r_rsp_sync <= m_shk_smiso;
            r_rsp_data <= m_shk_dmiso;
            r_rsp_err  <= 1'b0;
         end else if (w_timeout) begin
            r_wvalid   <= 1'b0;
            r_rsp_sync <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_sticky   <= 1'b1;
         end else if ((r_state == StSend) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shk_seq_master.sv
// Directed testbench for shk_seq_master (NB_TIMEOUT overridden to 16).
module tb_shk_seq_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_sync;
   logic [14:0] req_data;
   logic        rsp_valid;
   logic [15:0] rsp_sync;
   logic [14:0] rsp_data;
   logic        rsp_err;
   logic        wvalid;
   logic [15:0] smosi;
   logic [14:0] dmosi;
   logic        wready;
   logic [15:0] smiso;
   logic [14:0] dmiso;
   logic [3:0]  err_in;
   logic [3:0]  err_out;

   int n_pass  = 0;
   int n_total = 0;

   shk_seq_master #(
      .NB_VER      (0),
      .WD_SHK_SYNC (16),
      .WD_SHK_DLAY (15),
      .WD_ERR_INFO (4),
      .NB_TIMEOUT  (16)
   ) u_dut (
      .s_sys_a_clock  (clk),
      .s_sys_a_resetn (rst_n),
      .s_req_valid    (req_valid),
      .s_req_ready    (req_ready),
      .s_req_sync     (req_sync),
      .s_req_data     (req_data),
      .m_rsp_valid    (rsp_valid),
      .m_rsp_sync     (rsp_sync),
      .m_rsp_data     (rsp_data),
      .m_rsp_err      (rsp_err),
      .m_shk_wvalid   (wvalid),
      .m_shk_smosi    (smosi),
      .m_shk_dmosi    (dmosi),
      .m_shk_wready   (wready),
      .m_shk_smiso    (smiso),
      .m_shk_dmiso    (dmiso),
      .s_err_info1    (err_in),
      .m_err_info1    (err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_sync  = '0;
      req_data  = '0;
      wready    = 1'b0;
      smiso     = '0;
      dmiso     = '0;
      err_in    = '0;

      // Reset state
      #2;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
      chk("rst_err_out", 32'(err_out), 32'd0);
      tick();
      tick();
      chk("rst_ready_hold", 32'(req_ready), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      // Single write: wready after 3 SHK cycles, wvalid high 4 cycles
      req_valid = 1'b1;
      req_sync  = 16'h0001;
      req_data  = 15'h1234;
      tick();
      req_valid = 1'b0;
      chk("w1_wvalid_c1", 32'(wvalid), 32'd1);
      chk("w1_smosi", 32'(smosi), 32'h0001);
      chk("w1_dmosi", 32'(dmosi), 32'h1234);
      chk("w1_ready_send", 32'(req_ready), 32'd0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("w1_wvalid_hold", 32'(wvalid), 32'd1);
         chk("w1_no_rsp", 32'(rsp_valid), 32'd0);
      end
      wready = 1'b1;
      smiso  = 16'h8001;
      dmiso  = 15'h0055;
      tick();
      wready = 1'b0;
      chk("w1_wvalid_drop", 32'(wvalid), 32'd0);
      chk("w1_no_rsp_rel", 32'(rsp_valid), 32'd0);
      tick();
      chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w1_rsp_sync", 32'(rsp_sync), 32'h8001);
      chk("w1_rsp_data", 32'(rsp_data), 32'h0055);
      chk("w1_rsp_err", 32'(rsp_err), 32'd0);
      tick();
      chk("w1_rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("w1_ready_idle", 32'(req_ready), 32'd1);
      chk("w1_rsp_hold", 32'(rsp_sync), 32'h8001);

      // Wready in IDLE is ignored
      wready = 1'b1;
      smiso  = 16'hdead;
      tick();
      tick();
      chk("idle_wr_norsp", 32'(rsp_valid), 32'd0);
      chk("idle_wr_nocap", 32'(rsp_sync), 32'h8001);
      wready = 1'b0;
      tick();

      // Four-phase: wready held 5 cycles after wvalid drops
      req_valid = 1'b1;
      req_sync  = 16'h0002;
      req_data  = 15'h0abc;
      tick();
      req_valid = 1'b0;
      wready    = 1'b1;
      smiso     = 16'h4242;
      dmiso     = 15'h1357;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("fp_wvalid_low", 32'(wvalid), 32'd0);
         chk("fp_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      wready = 1'b0;
      tick();
      chk("fp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("fp_rsp_sync", 32'(rsp_sync), 32'h4242);
      chk("fp_rsp_data", 32'(rsp_data), 32'h1357);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fp_single_rsp", 32'(rsp_valid), 32'd0);
      end

      // Timeout: slave never ready, wvalid high exactly 16 cycles
      req_valid = 1'b1;
      req_sync  = 16'h0003;
      req_data  = 15'h0001;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("to_wvalid_high", 32'(wvalid), 32'd1);
         tick();
      end
      chk("to_wvalid_drop", 32'(wvalid), 32'd0);
      chk("to_rsp_err", 32'(rsp_err), 32'd1);
      chk("to_rsp_sync0", 32'(rsp_sync), 32'd0);
      chk("to_rsp_data0", 32'(rsp_data), 32'd0);
      chk("to_err_msb", 32'(err_out), 32'h8);
      tick();
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      chk("to_rsp_pulse", 32'(rsp_valid), 32'd0);
      err_in = 4'b0011;
      #1;
      chk("to_err_merge", 32'(err_out), 32'hb);
      err_in = 4'b0000;

      // Boundary: wready first sampled on SHK cycle 16 completes normally
      req_valid = 1'b1;
      req_sync  = 16'h0004;
      req_data  = 15'h0002;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      chk("bd_wvalid_c16", 32'(wvalid), 32'd1);
      wready = 1'b1;
      smiso  = 16'h1111;
      dmiso  = 15'h2222;
      tick();
      wready = 1'b0;
      chk("bd_wvalid_drop", 32'(wvalid), 32'd0);
      chk("bd_rsp_err", 32'(rsp_err), 32'd0);
      chk("bd_rsp_sync", 32'(rsp_sync), 32'h1111);
      tick();
      chk("bd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bd_rsp_data", 32'(rsp_data), 32'h2222);
      tick();

      // Back-to-back: valid held high for three commands
      req_valid = 1'b1;
      req_sync  = 16'h0a00;
      req_data  = 15'h0100;
      for (int k = 0; k < 3; k++) begin
         chk("bb_ready_idle", 32'(req_ready), 32'd1);
         tick();
         chk("bb_smosi", 32'(smosi), 32'(16'h0a00 + 16'(k)));
         chk("bb_dmosi", 32'(dmosi), 32'(15'h0100 + 15'(k)));
         chk("bb_ready_send", 32'(req_ready), 32'd0);
         if (k < 2) begin
            req_sync = 16'h0a00 + 16'(k + 1);
            req_data = 15'h0100 + 15'(k + 1);
         end
         wready = 1'b1;
         smiso  = 16'hc000 + 16'(k);
         tick();
         wready = 1'b0;
         chk("bb_ready_rel", 32'(req_ready), 32'd0);
         chk("bb_wvalid_low", 32'(wvalid), 32'd0);
         tick();
         chk("bb_ready_resp", 32'(req_ready), 32'd0);
         chk("bb_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bb_rsp_sync", 32'(rsp_sync), 32'(16'hc000 + 16'(k)));
         if (k == 2) req_valid = 1'b0;
         tick();
      end
      chk("bb_done_idle", 32'(wvalid), 32'd0);
      chk("sticky_stays", 32'(err_out), 32'h8);

      // Reset asserted while in SEND
      req_valid = 1'b1;
      req_sync  = 16'h0005;
      req_data  = 15'h0003;
      tick();
      req_valid = 1'b0;
      chk("rs_wvalid_pre", 32'(wvalid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("rs_wvalid_async", 32'(wvalid), 32'd0);
      chk("rs_ready", 32'(req_ready), 32'd0);
      wready = 1'b1;
      tick();
      chk("rs_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rs_sticky_clr", 32'(err_out), 32'd0);
      #3 rst_n = 1'b1;
      wready = 1'b0;
      tick();
      chk("rs_ready_back", 32'(req_ready), 32'd1);
      chk("rs_no_rsp2", 32'(rsp_valid), 32'd0);
      req_valid = 1'b1;
      req_sync  = 16'h0006;
      req_data  = 15'h0777;
      tick();
      req_valid = 1'b0;
      chk("rs2_wvalid", 32'(wvalid), 32'd1);
      chk("rs2_smosi", 32'(smosi), 32'h0006);
      wready = 1'b1;
      smiso  = 16'h7e7e;
      dmiso  = 15'h0666;
      tick();
      wready = 1'b0;
      tick();
      chk("rs2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rs2_rsp_sync", 32'(rsp_sync), 32'h7e7e);
      chk("rs2_rsp_data", 32'(rsp_data), 32'h0666);
      chk("rs2_rsp_err", 32'(rsp_err), 32'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
